// File: rtl/wb_board_io_if.sv
// ---------------------------------------------------------------------------
// wb_board_io_if
//   Wishbone classic bus bundle for the board I/O slave.
//   Signal names are seen from the slave, so *_i flows master->slave and
//   *_o flows slave->master.
//     cyc_i, stb_i, we_i : cycle, strobe and write enable
//     adr_i[3:0]         : word address
//     dat_i[31:0]        : write data
//     dat_o[31:0]        : read data (registered, valid while ack_o=1)
//     ack_o              : single-cycle acknowledge
// ---------------------------------------------------------------------------
interface wb_board_io_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/wb_board_io.sv
// ---------------------------------------------------------------------------
// wb_board_io
//   Wishbone classic slave for the board buttons, switches, green LEDs and
//   RGB LEDs. Buttons and switches are synchronised and debounced, button
//   presses latch into a W1C event register with a maskable level interrupt,
//   green LEDs follow a register and RGB LEDs are driven by 8-bit PWM whose
//   duty values are only picked up at the start of a PWM period.
//
//   Ports:
//     clk_i      : clock
//     rst_i      : synchronous active-high reset
//     wb         : Wishbone slave bundle (cyc/stb/we/adr/dat_i/dat_o/ack)
//     buttons    : asynchronous button pins
//     switches   : asynchronous switch pins
//     green_leds : green LED outputs
//     rgb_leds   : RGB LED outputs, LED i uses bits 3i (R), 3i+1 (G), 3i+2 (B)
//     irq_o      : level interrupt, |(EVT & IRQ_MASK) registered
//
//   Register map (word address):
//     0x0 BTN (RO)  0x1 SW (RO)  0x2 EVT (W1C)  0x3 GREEN  0x4 CTRL[0]=PWM en
//     0x5 IRQ_MASK  0x8+i RGB[i] duty {B[23:16], G[15:8], R[7:0]}
// ---------------------------------------------------------------------------
module wb_board_io #(
    parameter int NUM_BUTTONS     = 4,
    parameter int NUM_SWITCHES    = 4,
    parameter int NUM_GREEN       = 4,
    parameter int NUM_RGB         = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PWM_DIV         = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    wb_board_io_if.slave             wb,
    input  logic [NUM_BUTTONS-1:0]   buttons,
    input  logic [NUM_SWITCHES-1:0]  switches,
    output logic [NUM_GREEN-1:0]     green_leds,
    output logic [3*NUM_RGB-1:0]     rgb_leds,
    output logic                     irq_o
);

    localparam int NIN   = NUM_BUTTONS + NUM_SWITCHES;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);

    // ---------------- input synchroniser and debounce ----------------
    logic [NIN-1:0]   w_pins;
    logic [NIN-1:0]   r_sync_p0;
    logic [NIN-1:0]   r_sync_p1;
    logic [NIN-1:0]   r_db_lvl;
    logic [CNT_W-1:0] r_db_cnt [NIN];

    assign w_pins = {switches, buttons};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_db_lvl  <= '0;
            for (int i = 0; i < NIN; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync_p0 <= w_pins;
            r_sync_p1 <= r_sync_p0;
            for (int i = 0; i < NIN; i++) begin
                if (r_sync_p1[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CNT_MAX) begin
                    r_db_lvl[i] <= ~r_db_lvl[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [NUM_BUTTONS-1:0]  w_btn;
    logic [NUM_SWITCHES-1:0] w_sw;
    logic [NUM_BUTTONS-1:0]  w_btn_rise;

    assign w_btn = r_db_lvl[NUM_BUTTONS-1:0];
    assign w_sw  = r_db_lvl[NIN-1:NUM_BUTTONS];

    // A press is flagged on the same edge the debounced level toggles 0->1.
    always_comb begin
        w_btn_rise = '0;
        for (int i = 0; i < NUM_BUTTONS; i++)
            w_btn_rise[i] = r_sync_p1[i] & ~r_db_lvl[i] & (r_db_cnt[i] == CNT_MAX);
    end

    // ---------------- Wishbone register file ----------------
    logic                   r_ack;
    logic [31:0]            r_dat_o;
    logic [NUM_BUTTONS-1:0] r_evt;
    logic [NUM_BUTTONS-1:0] r_mask;
    logic [NUM_GREEN-1:0]   r_green;
    logic [NUM_GREEN-1:0]   r_green_out;
    logic                   r_pwm_en;
    logic                   r_irq;
    logic [23:0]            r_duty [8];

    logic                   w_req;
    logic                   w_wr;
    logic                   w_rd;
    logic [3:0]             w_adr;
    logic [2:0]             w_rgb_idx;
    logic                   w_rgb_sel;
    logic [31:0]            w_rdata;
    logic [NUM_BUTTONS-1:0] w_evt_clr;
    logic                   w_unused_bits;

    // ack_o low in the request condition gives one ack per strobe and
    // every-other-cycle acks while stb_i stays high.
    assign w_req     = wb.cyc_i & wb.stb_i & ~r_ack;
    assign w_wr      = w_req & wb.we_i;
    assign w_rd      = w_req & ~wb.we_i;
    assign w_adr     = wb.adr_i;
    assign w_rgb_idx = w_adr[2:0];
    assign w_rgb_sel = w_adr[3] && (32'(w_rgb_idx) < NUM_RGB);
    assign w_evt_clr = (w_wr && (w_adr == 4'h2)) ? wb.dat_i[NUM_BUTTONS-1:0] : '0;
    assign w_unused_bits = &{1'b0, wb.dat_i[31:24]};

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            4'h0: w_rdata[NUM_BUTTONS-1:0]  = w_btn;
            4'h1: w_rdata[NUM_SWITCHES-1:0] = w_sw;
            4'h2: w_rdata[NUM_BUTTONS-1:0]  = r_evt;
            4'h3: w_rdata[NUM_GREEN-1:0]    = r_green;
            4'h4: w_rdata[0]                = r_pwm_en;
            4'h5: w_rdata[NUM_BUTTONS-1:0]  = r_mask;
            default: if (w_rgb_sel) w_rdata[23:0] = r_duty[w_rgb_idx];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack       <= 1'b0;
            r_dat_o     <= '0;
            r_evt       <= '0;
            r_mask      <= '0;
            r_green     <= '0;
            r_green_out <= '0;
            r_pwm_en    <= 1'b0;
            r_irq       <= 1'b0;
            for (int i = 0; i < 8; i++) r_duty[i] <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= w_rd ? w_rdata : 32'h0;
            if (w_wr) begin
                case (w_adr)
                    4'h3: r_green  <= wb.dat_i[NUM_GREEN-1:0];
                    4'h4: r_pwm_en <= wb.dat_i[0];
                    4'h5: r_mask   <= wb.dat_i[NUM_BUTTONS-1:0];
                    default: if (w_rgb_sel) r_duty[w_rgb_idx] <= wb.dat_i[23:0];
                endcase
            end
            // A new press beats a simultaneous write-1-to-clear.
            r_evt       <= (r_evt & ~w_evt_clr) | w_btn_rise;
            r_irq       <= |(r_evt & r_mask);
            r_green_out <= r_green;
        end
    end

    // ---------------- PWM ----------------
    logic [PRE_W-1:0]    r_pre;
    logic [7:0]          r_pwm_cnt;
    logic [23:0]         r_shadow [NUM_RGB];
    logic [3*NUM_RGB-1:0] r_rgb;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pre     <= '0;
            r_pwm_cnt <= '0;
            r_rgb     <= '0;
            for (int i = 0; i < NUM_RGB; i++) r_shadow[i] <= '0;
        end else begin
            if (r_pre == PRE_MAX) begin
                r_pre     <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
                // Duties are sampled only when a new period starts, so a
                // bus write never reshapes the period in flight.
                if (r_pwm_cnt == 8'hFF)
                    for (int i = 0; i < NUM_RGB; i++) r_shadow[i] <= r_duty[i];
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            for (int i = 0; i < NUM_RGB; i++)
                for (int c = 0; c < 3; c++)
                    r_rgb[3*i+c] <= r_pwm_en && (r_pwm_cnt < r_shadow[i][8*c +: 8]);
        end
    end

    assign wb.ack_o   = r_ack;
    assign wb.dat_o   = r_dat_o;
    assign green_leds = r_green_out;
    assign rgb_leds   = r_rgb;
    assign irq_o      = r_irq;

endmodule

// File: tb/tb_wb_board_io.sv
module tb_wb_board_io;
    localparam int NB = 4;
    localparam int NS = 4;
    localparam int NG = 4;
    localparam int NR = 4;
    localparam int DB = 4;
    localparam int PD = 1;

    logic clk = 1'b0;
    logic rst;
    logic [NB-1:0]   buttons;
    logic [NS-1:0]   switches;
    logic [NG-1:0]   green_leds;
    logic [3*NR-1:0] rgb_leds;
    logic            irq_o;

    always #5 clk = ~clk;

    wb_board_io_if wb ();

    wb_board_io #(
        .NUM_BUTTONS(NB), .NUM_SWITCHES(NS), .NUM_GREEN(NG), .NUM_RGB(NR),
        .DEBOUNCE_CYCLES(DB), .PWM_DIV(PD)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wb(wb),
        .buttons(buttons), .switches(switches),
        .green_leds(green_leds), .rgb_leds(rgb_leds), .irq_o(irq_o)
    );

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic we, input logic [3:0] adr,
                           input logic [31:0] wdat, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.adr = adr; v.wdat = wdat; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Called on a negedge, returns on a negedge. Reads push their expected
    // data to the scoreboard; the ack pops and compares it.
    task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                           input logic [31:0] exp, input string name);
        int          lat;
        logic        got;
        logic [31:0] e;
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we; wb.adr_i = adr; wb.dat_i = wdat;
        if (!we) exp_q.push_back(exp);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 4) begin
            @(negedge clk);
            lat++;
            if (wb.ack_o) got = 1'b1;
        end
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        check({name, "_acklat"}, got ? 32'(lat) : 32'd0, 32'd1);
        if (!we) begin
            e = exp_q.pop_front();
            if (got) check({name, "_data"}, wb.dat_o, e);
        end
        @(negedge clk);
        check({name, "_ackdrop"}, {31'd0, wb.ack_o}, 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : main
        int acks;
        int irqs;
        int found;
        int waitc;
        logic prev;
        int r1, g1, b1, r2, g2, b2;

        rst = 1'b1;
        buttons = '0; switches = '0;
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0; wb.adr_i = '0; wb.dat_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", {31'd0, wb.ack_o}, 0);
        check("rst_dat", wb.dat_o, 0);
        check("rst_green", {28'd0, green_leds}, 0);
        check("rst_rgb", {20'd0, rgb_leds}, 0);
        check("rst_irq", {31'd0, irq_o}, 0);

        // Register table
        for (int a = 0; a < 6; a++) add_vec(1'b0, 4'(a), 32'h0, 32'h0);
        add_vec(1'b0, 4'h8, 32'h0, 32'h0);
        add_vec(1'b1, 4'h3, 32'hFFFF_FFFF, 32'h0);
        add_vec(1'b0, 4'h3, 32'h0, 32'h0000_000F);
        add_vec(1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0);
        add_vec(1'b0, 4'hF, 32'h0, 32'h0);
        add_vec(1'b1, 4'hC, 32'h0000_0123, 32'h0);
        add_vec(1'b0, 4'hC, 32'h0, 32'h0);
        add_vec(1'b1, 4'hB, 32'h1234_5678, 32'h0);
        add_vec(1'b0, 4'hB, 32'h0, 32'h0034_5678);
        add_vec(1'b1, 4'h5, 32'hFFFF_FFFF, 32'h0);
        add_vec(1'b0, 4'h5, 32'h0, 32'h0000_000F);
        add_vec(1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0);
        add_vec(1'b0, 4'h4, 32'h0, 32'h0000_0001);
        add_vec(1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0);
        add_vec(1'b0, 4'h0, 32'h0, 32'h0);
        add_vec(1'b0, 4'h1, 32'h0, 32'h0);
        add_vec(1'b1, 4'h4, 32'h0, 32'h0);
        add_vec(1'b1, 4'h5, 32'h0000_0002, 32'h0);
        for (int i = 0; i < tbl.size(); i++)
            wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].wdat, tbl[i].exp, $sformatf("vec%0d", i));
        check("green_pins", {28'd0, green_leds}, 32'hF);

        // stb without cyc
        acks = 0;
        wb.stb_i = 1'b1; wb.cyc_i = 1'b0; wb.adr_i = 4'h0;
        repeat (3) begin @(negedge clk); if (wb.ack_o) acks++; end
        wb.stb_i = 1'b0;
        check("stb_no_cyc_acks", 32'(acks), 0);

        // stb held six cycles
        acks = 0;
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = 4'h0;
        repeat (6) begin @(negedge clk); if (wb.ack_o) acks++; end
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0;
        check("held_stb_acks", 32'(acks), 3);
        @(negedge clk);
        check("held_stb_ackdrop", {31'd0, wb.ack_o}, 0);

        // Glitch of 3 cycles must not propagate
        irqs = 0;
        buttons[1] = 1'b1;
        repeat (3) @(negedge clk);
        buttons[1] = 1'b0;
        repeat (12) begin @(negedge clk); if (irq_o) irqs++; end
        check("glitch_irq", 32'(irqs), 0);
        wb_xfer(1'b0, 4'h0, 32'h0, 32'h0, "glitch_btn");
        wb_xfer(1'b0, 4'h2, 32'h0, 32'h0, "glitch_evt");

        // Clean press: debounced at edge 6, irq at edge 7
        buttons[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) check("press_irq_at6", {31'd0, irq_o}, 0);
            if (k == 7) check("press_irq_at7", {31'd0, irq_o}, 1);
        end
        wb_xfer(1'b0, 4'h0, 32'h0, 32'h2, "press_btn");
        wb_xfer(1'b0, 4'h2, 32'h0, 32'h2, "press_evt");

        // W1C clear
        wb_xfer(1'b1, 4'h2, 32'h2, 32'h0, "evt_clr_wr");
        wb_xfer(1'b0, 4'h2, 32'h0, 32'h0, "evt_clr_rd");
        check("evt_clr_irq", {31'd0, irq_o}, 0);

        // Set beats clear in the same cycle
        buttons[1] = 1'b0;
        repeat (10) @(negedge clk);
        wb_xfer(1'b0, 4'h0, 32'h0, 32'h0, "release_btn");
        buttons[1] = 1'b1;
        repeat (5) @(negedge clk);
        wb_xfer(1'b1, 4'h2, 32'h2, 32'h0, "conflict_wr");
        wb_xfer(1'b0, 4'h2, 32'h0, 32'h2, "conflict_evt");
        check("conflict_irq", {31'd0, irq_o}, 1);

        // Reset aborting a write strobe
        buttons = '0;
        wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = 4'h3; wb.dat_i = 32'h5;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ack", {31'd0, wb.ack_o}, 0);
        check("abort_green", {28'd0, green_leds}, 0);
        check("abort_rgb", {20'd0, rgb_leds}, 0);
        check("abort_irq", {31'd0, irq_o}, 0);
        wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        wb_xfer(1'b0, 4'h3, 32'h0, 32'h0, "abort_green_rd");

        // PWM
        wb_xfer(1'b1, 4'h8, 32'h0000_FF40, 32'h0, "pwm_duty_wr");
        wb_xfer(1'b1, 4'h4, 32'h1, 32'h0, "pwm_en_wr");
        found = 0; waitc = 0; prev = 1'b1;
        while (!found && waitc < 600) begin
            @(negedge clk);
            waitc++;
            if (rgb_leds[0] && !prev) found = 1;
            prev = rgb_leds[0];
        end
        check("pwm_period_found", 32'(found), 1);
        r1 = 1; g1 = rgb_leds[1] ? 1 : 0; b1 = rgb_leds[2] ? 1 : 0;
        fork
            begin
                for (int s = 1; s < 256; s++) begin
                    @(negedge clk);
                    if (rgb_leds[0]) r1++;
                    if (rgb_leds[1]) g1++;
                    if (rgb_leds[2]) b1++;
                end
            end
            begin
                repeat (100) @(negedge clk);
                wb_xfer(1'b1, 4'h8, 32'h0000_FF80, 32'h0, "pwm_mid_wr");
            end
        join
        r2 = 0; g2 = 0; b2 = 0;
        for (int s = 0; s < 256; s++) begin
            @(negedge clk);
            if (rgb_leds[0]) r2++;
            if (rgb_leds[1]) g2++;
            if (rgb_leds[2]) b2++;
        end
        check("pwm_red_p1", 32'(r1), 64);
        check("pwm_green_p1", 32'(g1), 255);
        check("pwm_blue_p1", 32'(b1), 0);
        check("pwm_red_p2", 32'(r2), 128);
        check("pwm_green_p2", 32'(g2), 255);
        check("pwm_blue_p2", 32'(b2), 0);

        wb_xfer(1'b1, 4'h4, 32'h0, 32'h0, "pwm_dis_wr");
        repeat (3) @(negedge clk);
        acks = 0;
        repeat (300) begin @(negedge clk); if (rgb_leds != '0) acks++; end
        check("pwm_disabled_rgb", 32'(acks), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
